// File: rtl/nes_bus_pkg.sv
// Shared definitions for the NES CPU memory bus: widths, arbiter state
// encoding and the default park address used while the host idles on the bus.
package nes_bus_pkg;

    localparam int CPU_A_W = 16;
    localparam int D_W     = 8;
    localparam int CNT_W   = 8;

    localparam logic [CPU_A_W-1:0] PARK_ADDR_DEFAULT = 16'h0000;

    typedef enum logic [2:0] {
        CPU_OWN,
        DRAIN,
        HOST_IDLE,
        ACCESS,
        ACK,
        RELEASE
    } arb_state_e;

    function automatic logic host_owns(input arb_state_e s);
        return (s == HOST_IDLE) || (s == ACCESS) || (s == ACK);
    endfunction

endpackage

// File: rtl/bus_arb_counter.sv
// Loadable down-counter that stops at zero; load has priority over decrement.
module bus_arb_counter
    import nes_bus_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk_in,
    input  logic         nres_in,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk_in or negedge nres_in) begin
        if (!nres_in) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Sequenced handover of the CPU memory bus between the rp2a03 core and the
// host debug interface: stall, drain, single host accesses, then give back.
module cpu_bus_arbiter
    import nes_bus_pkg::*;
#(
    parameter int                  DRAIN_CYCLES = 2,
    parameter int                  RD_LAT       = 1,
    parameter int                  BURST_MAX    = 16,
    parameter int                  CPU_SLOT     = 8,
    parameter logic [CPU_A_W-1:0]  PARK_ADDR    = PARK_ADDR_DEFAULT
) (
    input  logic               clk_in,
    input  logic               nres_in,
    input  logic [CPU_A_W-1:0] cpu_a_in,
    input  logic               cpu_r_nw_in,
    input  logic [D_W-1:0]     cpu_d_in,
    output logic               cpu_rdy_out,
    input  logic               host_req_in,
    input  logic               host_hold_in,
    input  logic [CPU_A_W-1:0] host_a_in,
    input  logic               host_r_nw_in,
    input  logic [D_W-1:0]     host_d_in,
    output logic               host_ack_out,
    output logic [D_W-1:0]     host_d_out,
    output logic               host_active_out,
    output logic [CPU_A_W-1:0] bus_a_out,
    output logic               bus_r_nw_out,
    output logic [D_W-1:0]     bus_d_out,
    input  logic [D_W-1:0]     bus_d_in
);

    localparam int CNT_DRAIN = 0;
    localparam int CNT_RDLAT = 1;
    localparam int CNT_SLOT  = 2;

    arb_state_e         state_reg, state_next;
    logic [2:0]         cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]   cnt_val [3];
    logic [CNT_W-1:0]   burst_reg;
    logic               burst_full, fair_release, host_want;
    logic [CPU_A_W-1:0] lat_a_reg;
    logic               lat_r_nw_reg;
    logic [D_W-1:0]     lat_d_reg;
    logic               cpu_rdy_reg, host_ack_reg, host_active_reg;
    logic [D_W-1:0]     host_d_reg;

    assign host_want    = host_req_in || host_hold_in;
    assign burst_full   = (burst_reg == CNT_W'(BURST_MAX));
    assign fair_release = (state_reg == HOST_IDLE) && burst_full && !host_hold_in;

    // Drain, read-latency and CPU-slot timers share one counter implementation.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            bus_arb_counter #(.W(CNT_W)) u_cnt (
                .clk_in   (clk_in),
                .nres_in  (nres_in),
                .load     (cnt_load[gi]),
                .load_val (cnt_val[gi]),
                .dec      (cnt_dec[gi]),
                .zero     (cnt_zero[gi])
            );
        end
    endgenerate

    always_comb begin
        cnt_load            = '0;
        cnt_dec             = '0;
        cnt_val[CNT_DRAIN]  = CNT_W'(DRAIN_CYCLES - 1);
        cnt_val[CNT_RDLAT]  = CNT_W'(RD_LAT - 1);
        cnt_val[CNT_SLOT]   = fair_release ? CNT_W'(CPU_SLOT) : '0;
        cnt_load[CNT_DRAIN] = (state_reg == CPU_OWN) && (state_next == DRAIN);
        cnt_dec[CNT_DRAIN]  = (state_reg == DRAIN);
        cnt_load[CNT_RDLAT] = (state_reg == HOST_IDLE) && (state_next == ACCESS);
        cnt_dec[CNT_RDLAT]  = (state_reg == ACCESS);
        cnt_load[CNT_SLOT]  = (state_reg != RELEASE) && (state_next == RELEASE);
        cnt_dec[CNT_SLOT]   = (state_reg == CPU_OWN);
    end

    always_ff @(posedge clk_in or negedge nres_in) begin
        if (!nres_in) begin
            state_reg <= CPU_OWN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            CPU_OWN:   if (host_want && cnt_zero[CNT_SLOT]) state_next = DRAIN;
            // The abort check waits for the drain to finish so the CPU's last cycle completes.
            DRAIN:     if (cnt_zero[CNT_DRAIN]) state_next = host_want ? HOST_IDLE : RELEASE;
            HOST_IDLE: begin
                if (fair_release)       state_next = RELEASE;
                else if (host_req_in)   state_next = ACCESS;
                else if (!host_hold_in) state_next = RELEASE;
            end
            ACCESS:    if (!lat_r_nw_reg || cnt_zero[CNT_RDLAT]) state_next = ACK;
            ACK:       state_next = HOST_IDLE;
            RELEASE:   state_next = CPU_OWN;
            default:   state_next = CPU_OWN;
        endcase
    end

    always_ff @(posedge clk_in or negedge nres_in) begin
        if (!nres_in) begin
            cpu_rdy_reg     <= 1'b1;
            host_ack_reg    <= 1'b0;
            host_active_reg <= 1'b0;
            host_d_reg      <= '0;
            burst_reg       <= '0;
            lat_a_reg       <= '0;
            lat_r_nw_reg    <= 1'b1;
            lat_d_reg       <= '0;
        end else begin
            cpu_rdy_reg     <= (state_next == CPU_OWN) || (state_next == RELEASE);
            host_ack_reg    <= (state_next == ACK);
            host_active_reg <= host_owns(state_next);
            if ((state_reg == HOST_IDLE) && (state_next == ACCESS)) begin
                lat_a_reg    <= host_a_in;
                lat_r_nw_reg <= host_r_nw_in;
                lat_d_reg    <= host_d_in;
            end
            if ((state_reg == ACCESS) && lat_r_nw_reg && cnt_zero[CNT_RDLAT]) begin
                host_d_reg <= bus_d_in;
            end
            if (state_reg == CPU_OWN) begin
                burst_reg <= '0;
            end else if ((state_reg == ACK) && !burst_full) begin
                burst_reg <= burst_reg + CNT_W'(1);
            end
        end
    end

    // Idle host ownership parks on a side-effect-free address so PPU registers are never touched.
    always_comb begin
        bus_a_out    = cpu_a_in;
        bus_r_nw_out = cpu_r_nw_in;
        bus_d_out    = cpu_d_in;
        case (state_reg)
            HOST_IDLE, ACK: begin
                bus_a_out    = PARK_ADDR;
                bus_r_nw_out = 1'b1;
                bus_d_out    = '0;
            end
            ACCESS: begin
                bus_a_out    = lat_a_reg;
                bus_r_nw_out = lat_r_nw_reg;
                bus_d_out    = lat_d_reg;
            end
            default: ;
        endcase
    end

    assign cpu_rdy_out     = cpu_rdy_reg;
    assign host_ack_out    = host_ack_reg;
    assign host_active_out = host_active_reg;
    assign host_d_out      = host_d_reg;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter: cold grant, held grant with write,
// fairness release, drain abort, reset during access and ack/req overlap.
module tb_cpu_bus_arbiter;

    logic        CLK_100MHZ = 1'b0;
    logic        nres_in;
    logic [15:0] cpu_a_in;
    logic        cpu_r_nw_in;
    logic [7:0]  cpu_d_in;
    logic        cpu_rdy_out;
    logic        host_req_in;
    logic        host_hold_in;
    logic [15:0] host_a_in;
    logic        host_r_nw_in;
    logic [7:0]  host_d_in;
    logic        host_ack_out;
    logic [7:0]  host_d_out;
    logic        host_active_out;
    logic [15:0] bus_a_out;
    logic        bus_r_nw_out;
    logic [7:0]  bus_d_out;
    logic [7:0]  bus_d_in;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int ack_cnt = 0;
    int park_bad = 0;

    bit [7:0] wram    [65536];
    bit       wram_wr [65536];

    always #5 CLK_100MHZ = ~CLK_100MHZ;

    cpu_bus_arbiter dut (
        .clk_in          (CLK_100MHZ),
        .nres_in         (nres_in),
        .cpu_a_in        (cpu_a_in),
        .cpu_r_nw_in     (cpu_r_nw_in),
        .cpu_d_in        (cpu_d_in),
        .cpu_rdy_out     (cpu_rdy_out),
        .host_req_in     (host_req_in),
        .host_hold_in    (host_hold_in),
        .host_a_in       (host_a_in),
        .host_r_nw_in    (host_r_nw_in),
        .host_d_in       (host_d_in),
        .host_ack_out    (host_ack_out),
        .host_d_out      (host_d_out),
        .host_active_out (host_active_out),
        .bus_a_out       (bus_a_out),
        .bus_r_nw_out    (bus_r_nw_out),
        .bus_d_out       (bus_d_out),
        .bus_d_in        (bus_d_in)
    );

    // Unwritten locations return a fixed pattern; written ones return stored data.
    function automatic logic [7:0] rom_val(input logic [15:0] a);
        case (a)
            16'h0005: return 8'hA5;
            16'h0020: return 8'h11;
            16'h0021: return 8'h22;
            default:  return a[7:0] ^ 8'hC3;
        endcase
    endfunction

    assign bus_d_in = !bus_r_nw_out ? 8'h00 :
                      (wram_wr[bus_a_out] ? wram[bus_a_out] : rom_val(bus_a_out));

    always @(posedge CLK_100MHZ) begin
        if (!bus_r_nw_out) begin
            wr_cnt++;
            wram[bus_a_out]    <= bus_d_out;
            wram_wr[bus_a_out] <= 1'b1;
        end
        if (host_ack_out) ack_cnt++;
        if (host_active_out && bus_r_nw_out && (bus_a_out == 16'h2002)) park_bad++;
    end

    task automatic tick();
        @(posedge CLK_100MHZ);
        #1;
    endtask

    task automatic test_reset();
        nres_in = 1'b0; host_req_in = 1'b0; host_hold_in = 1'b0;
        host_a_in = 16'h0000; host_r_nw_in = 1'b1; host_d_in = 8'h00;
        cpu_a_in = 16'h8123; cpu_r_nw_in = 1'b1; cpu_d_in = 8'h00;
        tick(); tick();
        n_cmp++; if (cpu_rdy_out !== 1'b1) begin n_bad++; $display("FAIL reset_rdy got=%b exp=1", cpu_rdy_out); end
        n_cmp++; if (host_ack_out !== 1'b0) begin n_bad++; $display("FAIL reset_ack got=%b exp=0", host_ack_out); end
        n_cmp++; if (host_d_out !== 8'h00) begin n_bad++; $display("FAIL reset_hd got=%h exp=00", host_d_out); end
        n_cmp++; if (host_active_out !== 1'b0) begin n_bad++; $display("FAIL reset_active got=%b exp=0", host_active_out); end
        n_cmp++; if (bus_a_out !== 16'h8123) begin n_bad++; $display("FAIL reset_bus_a got=%h exp=8123", bus_a_out); end
        nres_in = 1'b1;
        tick(); tick();
        $display("reset: bus_a=%h rdy=%b", bus_a_out, cpu_rdy_out);
    endtask

    task automatic test_cold_read();
        int ack_cyc;
        ack_cyc = 0;
        cpu_a_in = 16'h8000;
        host_a_in = 16'h0005; host_r_nw_in = 1'b1; host_req_in = 1'b1;
        tick();
        n_cmp++; if (cpu_rdy_out !== 1'b0) begin n_bad++; $display("FAIL cold_rdy_drop got=%b exp=0", cpu_rdy_out); end
        for (int c = 2; c <= 12; c++) begin
            tick();
            if (host_ack_out) begin ack_cyc = c; break; end
        end
        n_cmp++; if (ack_cyc != 5) begin n_bad++; $display("FAIL cold_ack_cycle got=%0d exp=5", ack_cyc); end
        n_cmp++; if (host_d_out !== 8'hA5) begin n_bad++; $display("FAIL cold_read_data got=%h exp=a5", host_d_out); end
        $display("cold read: a=0005 d=%h ack_cycle=%0d", host_d_out, ack_cyc);
        host_req_in = 1'b0;
        tick();
        n_cmp++; if (cpu_rdy_out !== 1'b0) begin n_bad++; $display("FAIL cold_rdy_early got=%b exp=0", cpu_rdy_out); end
        tick();
        n_cmp++; if (cpu_rdy_out !== 1'b1) begin n_bad++; $display("FAIL cold_rdy_return got=%b exp=1", cpu_rdy_out); end
        n_cmp++; if (host_active_out !== 1'b0) begin n_bad++; $display("FAIL cold_active_drop got=%b exp=0", host_active_out); end
        tick();
        n_cmp++; if (bus_a_out !== 16'h8000) begin n_bad++; $display("FAIL cold_cpu_bus got=%h exp=8000", bus_a_out); end
    endtask

    task automatic test_hold_write();
        int ack_cyc;
        int w0;
        ack_cyc = 0;
        cpu_a_in = 16'h2002; host_hold_in = 1'b1;
        for (int c = 0; c < 10 && !host_active_out; c++) tick();
        n_cmp++; if (host_active_out !== 1'b1) begin n_bad++; $display("FAIL hold_grant got=%b exp=1", host_active_out); end
        n_cmp++; if (bus_a_out !== 16'h0000) begin n_bad++; $display("FAIL park_addr got=%h exp=0000", bus_a_out); end
        n_cmp++; if (bus_r_nw_out !== 1'b1) begin n_bad++; $display("FAIL park_rnw got=%b exp=1", bus_r_nw_out); end
        w0 = wr_cnt;
        host_a_in = 16'h0010; host_r_nw_in = 1'b0; host_d_in = 8'h3C; host_req_in = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (host_ack_out) begin ack_cyc = c; break; end
        end
        host_req_in = 1'b0; host_r_nw_in = 1'b1;
        n_cmp++; if (ack_cyc != 2) begin n_bad++; $display("FAIL write_latency got=%0d exp=2", ack_cyc); end
        tick(); tick(); tick();
        n_cmp++; if ((wr_cnt - w0) != 1) begin n_bad++; $display("FAIL write_strobes got=%0d exp=1", wr_cnt - w0); end
        n_cmp++; if (wram[16] !== 8'h3C) begin n_bad++; $display("FAIL write_data got=%h exp=3c", wram[16]); end
        n_cmp++; if (host_active_out !== 1'b1) begin n_bad++; $display("FAIL hold_keep got=%b exp=1", host_active_out); end
        n_cmp++; if (bus_a_out !== 16'h0000) begin n_bad++; $display("FAIL park_after got=%h exp=0000", bus_a_out); end
        $display("held write: a=0010 d=3c strobes=%0d", wr_cnt - w0);
        host_hold_in = 1'b0;
        for (int c = 0; c < 10 && !cpu_rdy_out; c++) tick();
        n_cmp++; if (cpu_rdy_out !== 1'b1) begin n_bad++; $display("FAIL hold_release got=%b exp=1", cpu_rdy_out); end
        n_cmp++; if (park_bad != 0) begin n_bad++; $display("FAIL ppu_2002_reads got=%0d exp=0", park_bad); end
        cpu_a_in = 16'h8000;
        tick(); tick();
    endtask

    task automatic test_fairness();
        int acks;
        int first_rel;
        int rdy_run;
        int w0;
        logic [7:0] exp_d;
        acks = 0; first_rel = -1; rdy_run = 0; w0 = wr_cnt;
        host_hold_in = 1'b0; host_r_nw_in = 1'b1; host_a_in = 16'h0100; host_req_in = 1'b1;
        for (int c = 0; c < 600; c++) begin
            tick();
            if (cpu_rdy_out && (acks > 0) && (first_rel < 0)) first_rel = acks;
            if (cpu_rdy_out && (acks == 16)) rdy_run++;
            if (host_ack_out) begin
                exp_d = rom_val(host_a_in);
                n_cmp++; if (host_d_out !== exp_d) begin n_bad++; $display("FAIL burst_data a=%h got=%h exp=%h", host_a_in, host_d_out, exp_d); end
                $display("burst read %0d: a=%h d=%h", acks, host_a_in, host_d_out);
                acks++;
                if (acks == 20) begin
                    host_req_in = 1'b0;
                    break;
                end
                host_a_in = 16'h0100 + 16'(acks);
            end
        end
        n_cmp++; if (acks != 20) begin n_bad++; $display("FAIL burst_total got=%0d exp=20", acks); end
        n_cmp++; if (first_rel != 16) begin n_bad++; $display("FAIL fair_release_after got=%0d exp=16", first_rel); end
        n_cmp++; if (rdy_run < 8) begin n_bad++; $display("FAIL cpu_slot_len got=%0d exp>=8", rdy_run); end
        n_cmp++; if (wr_cnt != w0) begin n_bad++; $display("FAIL burst_no_write got=%0d exp=%0d", wr_cnt, w0); end
        for (int c = 0; c < 10 && !cpu_rdy_out; c++) tick();
        tick(); tick();
    endtask

    task automatic test_abort_drain();
        int a0;
        a0 = ack_cnt;
        host_r_nw_in = 1'b1; host_a_in = 16'h0005; host_req_in = 1'b1;
        tick();
        n_cmp++; if (cpu_rdy_out !== 1'b0) begin n_bad++; $display("FAIL abort_stall got=%b exp=0", cpu_rdy_out); end
        host_req_in = 1'b0;
        tick();
        n_cmp++; if (cpu_rdy_out !== 1'b0) begin n_bad++; $display("FAIL abort_drain_hold got=%b exp=0", cpu_rdy_out); end
        n_cmp++; if (bus_a_out !== 16'h8000) begin n_bad++; $display("FAIL abort_bus got=%h exp=8000", bus_a_out); end
        tick();
        n_cmp++; if (cpu_rdy_out !== 1'b1) begin n_bad++; $display("FAIL abort_rdy_return got=%b exp=1", cpu_rdy_out); end
        n_cmp++; if (host_active_out !== 1'b0) begin n_bad++; $display("FAIL abort_active got=%b exp=0", host_active_out); end
        n_cmp++; if (ack_cnt != a0) begin n_bad++; $display("FAIL abort_ack got=%0d exp=%0d", ack_cnt, a0); end
        $display("drain abort: rdy=%b acks=%0d", cpu_rdy_out, ack_cnt - a0);
        tick(); tick();
    endtask

    task automatic test_reset_mid_access();
        int a0;
        bit found;
        a0 = ack_cnt; found = 1'b0;
        host_a_in = 16'h0005; host_r_nw_in = 1'b1; host_req_in = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (host_active_out && (bus_a_out == 16'h0005)) begin found = 1'b1; break; end
        end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL rst_access_seen got=%b exp=1", found); end
        #2 nres_in = 1'b0;
        #1;
        n_cmp++; if (cpu_rdy_out !== 1'b1) begin n_bad++; $display("FAIL rst_rdy got=%b exp=1", cpu_rdy_out); end
        n_cmp++; if (host_active_out !== 1'b0) begin n_bad++; $display("FAIL rst_active got=%b exp=0", host_active_out); end
        n_cmp++; if (host_ack_out !== 1'b0) begin n_bad++; $display("FAIL rst_ack got=%b exp=0", host_ack_out); end
        n_cmp++; if (host_d_out !== 8'h00) begin n_bad++; $display("FAIL rst_hd got=%h exp=00", host_d_out); end
        n_cmp++; if (bus_a_out !== 16'h8000) begin n_bad++; $display("FAIL rst_bus got=%h exp=8000", bus_a_out); end
        host_req_in = 1'b0;
        tick(); tick();
        nres_in = 1'b1;
        tick(); tick();
        n_cmp++; if (ack_cnt != a0) begin n_bad++; $display("FAIL rst_no_ack got=%0d exp=%0d", ack_cnt, a0); end
        n_cmp++; if (bus_a_out !== 16'h8000) begin n_bad++; $display("FAIL rst_cpu_owns got=%h exp=8000", bus_a_out); end
        $display("reset mid-access: rdy=%b active=%b", cpu_rdy_out, host_active_out);
    endtask

    task automatic test_back_to_back();
        int acks;
        int first;
        int second;
        int a0;
        acks = 0; first = 0; second = 0; a0 = ack_cnt;
        host_a_in = 16'h0020; host_r_nw_in = 1'b1; host_req_in = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (host_ack_out) begin
                acks++;
                if (acks == 1) begin
                    first = c;
                    n_cmp++; if (host_d_out !== 8'h11) begin n_bad++; $display("FAIL overlap_d1 got=%h exp=11", host_d_out); end
                    $display("overlap read 1: a=0020 d=%h", host_d_out);
                    host_a_in = 16'h0021;
                end else if (acks == 2) begin
                    second = c;
                    n_cmp++; if (host_d_out !== 8'h22) begin n_bad++; $display("FAIL overlap_d2 got=%h exp=22", host_d_out); end
                    $display("overlap read 2: a=0021 d=%h", host_d_out);
                    host_req_in = 1'b0;
                end
            end
        end
        n_cmp++; if (acks != 2) begin n_bad++; $display("FAIL overlap_acks got=%0d exp=2", acks); end
        n_cmp++; if ((second - first) != 3) begin n_bad++; $display("FAIL overlap_gap got=%0d exp=3", second - first); end
        n_cmp++; if ((ack_cnt - a0) != 2) begin n_bad++; $display("FAIL overlap_pulses got=%0d exp=2", ack_cnt - a0); end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_hold_write();
        test_fairness();
        test_abort_drain();
        test_reset_mid_access();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
